// File: rtl/noc_pkg.sv
// noc_pkg: shared router constants, input port indices and allocator state encoding
package noc_pkg;
  localparam int NUM_PORTS = 5;
  typedef enum logic [2:0] {LOCAL = 3'd0, NORTH, EAST, SOUTH, WEST} port_e;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} alloc_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request at or after the start pointer, wrapping around
module rr_priority_picker #(
  parameter int NUM_PORTS = 5,
  parameter int SEL_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [SEL_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_onehot,
  output logic [SEL_W-1:0]     o_idx,
  output logic                 o_any
);
  always_comb begin
    o_onehot = '0;
    o_idx = '0;
    o_any = 1'b0;
    // farthest offset first so the port nearest the pointer overwrites last and wins
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      int j;
      j = int'(i_ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (i_req[j]) begin
        o_onehot = '0;
        o_onehot[j] = 1'b1;
        o_idx = SEL_W'(j);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wormhole_output_allocator.sv
// wormhole_output_allocator: round-robin owner of one output port, held from head to tail flit
module wormhole_output_allocator #(
  parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
  parameter int SEL_W = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] flit_valid,
  input  logic [NUM_PORTS-1:0] tail,
  input  logic                 on_off_signal,
  output logic [NUM_PORTS-1:0] grant,
  output logic [SEL_W-1:0]     sel,
  output logic                 xfer,
  output logic                 busy
);
  import noc_pkg::alloc_state_t;
  import noc_pkg::IDLE;
  import noc_pkg::LOCKED;
  alloc_state_t r_state, w_state;
  logic [SEL_W-1:0] r_ptr, w_ptr, r_sel, w_sel, w_next_ptr, w_pick_ptr, w_win_idx;
  logic [NUM_PORTS-1:0] r_grant, w_grant, w_pick_req, w_win;
  logic w_any, w_release;
  assign busy = (r_state == LOCKED);
  assign grant = r_grant;
  assign sel = r_sel;
  assign xfer = busy & flit_valid[r_sel] & on_off_signal;
  assign w_release = xfer & tail[r_sel];
  assign w_next_ptr = (r_sel == SEL_W'(NUM_PORTS - 1)) ? '0 : r_sel + SEL_W'(1);
  // while locked the picker only matters on release: owner masked, scan from the port after it
  assign w_pick_req = busy ? (req & ~r_grant) : req;
  assign w_pick_ptr = busy ? w_next_ptr : r_ptr;
  rr_priority_picker #(.NUM_PORTS(NUM_PORTS), .SEL_W(SEL_W)) u_pick (
    .i_req(w_pick_req),
    .i_ptr(w_pick_ptr),
    .o_onehot(w_win),
    .o_idx(w_win_idx),
    .o_any(w_any)
  );
  always_comb begin
    w_state = r_state;
    w_ptr = r_ptr;
    w_grant = r_grant;
    w_sel = r_sel;
    if (r_state == IDLE) begin
      if (w_any) begin
        w_state = LOCKED;
        w_grant = w_win;
        w_sel = w_win_idx;
      end
    end else if (w_release) begin
      w_ptr = w_next_ptr;
      w_grant = w_any ? w_win : '0;
      w_sel = w_any ? w_win_idx : r_sel;
      w_state = w_any ? LOCKED : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_grant <= '0;
      r_sel <= '0;
    end else begin
      r_state <= w_state;
      r_ptr <= w_ptr;
      r_grant <= w_grant;
      r_sel <= w_sel;
    end
  end
endmodule
